// File: rtl/leve1_pkg.sv
// Shared LEVE1 fetch-stage constants and the fetch FSM state type.
package leve1_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000;

  typedef enum logic [0:0] {
    IF_BOOT = 1'b0,
    IF_RUN  = 1'b1
  } if_state_t;

endpackage

// File: rtl/leve1_fetch_queue.sv
// Small synchronous FIFO with flush; used for the instruction queue and the PC-tag queue.
module leve1_fetch_queue #(
  parameter int W     = 96,
  parameter int DEPTH = 2,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk_sys,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  input  logic          flush,
  output logic [CW-1:0] count,
  output logic [W-1:0]  head
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Storage is reset so the head reads zero out of reset.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      assert (!(push && !pop && count == CW'(DEPTH)));
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (pop) rd_ptr <= next_ptr(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/leve1_if.sv
// LEVE1 instruction fetch: owns the PC, issues credit-limited word fetches,
// queues responses with their PCs for decode, and flushes on redirect.
//   state   | meaning
//   IF_BOOT | just out of reset, no requests
//   IF_RUN  | fetching
module leve1_if #(
  parameter int              XLEN     = leve1_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = leve1_pkg::RESET_PC,
  parameter int              QDEPTH   = 2
) (
  input  logic                       CLK,
  input  logic                       RST,
  output logic                       IMEM_REQ,
  output logic [XLEN-1:0]            IMEM_ADDR,
  input  logic                       IMEM_GNT,
  input  logic                       IMEM_RVALID,
  input  logic [leve1_pkg::ILEN-1:0] IMEM_RDATA,
  input  logic                       REDIRECT,
  input  logic [XLEN-1:0]            REDIRECT_PC,
  output logic                       OVALID,
  input  logic                       OREADY,
  output logic [XLEN-1:0]            OPC,
  output logic [leve1_pkg::ILEN-1:0] OINSTR
);

  import leve1_pkg::*;

  localparam int CW = $clog2(QDEPTH + 1);
  localparam int EW = XLEN + ILEN;

  if_state_t       state;
  logic [XLEN-1:0] pc;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   discard;
  logic [CW-1:0]   count;
  logic [CW-1:0]   tag_count;
  logic [XLEN-1:0] tag_pc;
  logic [EW-1:0]   head;
  logic            grant;
  logic            resp;
  logic            accept;
  logic            pop;

  // Credit: outstanding requests plus buffered entries never exceed the queue depth.
  assign IMEM_REQ  = (state == IF_RUN) && !REDIRECT &&
                     (({1'b0, inflight} + {1'b0, count}) < (CW + 1)'(QDEPTH));
  assign IMEM_ADDR = pc;
  assign grant     = IMEM_REQ && IMEM_GNT;
  assign resp      = IMEM_RVALID && (inflight != '0);
  assign accept    = resp && (discard == '0) && !REDIRECT && (tag_count != '0);
  assign OVALID    = (count != '0);
  assign pop       = OVALID && OREADY;
  assign {OPC, OINSTR} = head;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IF_BOOT;
    else     state <= IF_RUN;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc       <= RESET_PC;
      inflight <= '0;
      discard  <= '0;
    end else begin
      inflight <= inflight + CW'(grant) - CW'(resp);
      if (REDIRECT) begin
        pc      <= {REDIRECT_PC[XLEN-1:2], 2'b00};
        discard <= inflight - CW'(resp);
      end else begin
        if (grant) pc <= pc + XLEN'(4);
        if (resp && discard != '0) discard <= discard - 1'b1;
      end
    end
  end

  leve1_fetch_queue #(.W(EW), .DEPTH(QDEPTH)) u_queue (
    .clk_sys   (CLK),
    .rst       (RST),
    .push      (accept),
    .push_data ({tag_pc, IMEM_RDATA}),
    .pop       (pop),
    .flush     (REDIRECT),
    .count     (count),
    .head      (head)
  );

  // PC of each granted request, consumed in order as live responses return.
  leve1_fetch_queue #(.W(XLEN), .DEPTH(QDEPTH)) u_tags (
    .clk_sys   (CLK),
    .rst       (RST),
    .push      (grant),
    .push_data (pc),
    .pop       (accept),
    .flush     (REDIRECT),
    .count     (tag_count),
    .head      (tag_pc)
  );

endmodule
